// File: rtl/gamma_pkg.sv
// Shared widths, FSM state type and LUT curve for the gamma encode/decode path.
package gamma_pkg;

    localparam int unsigned LIN_W        = 12;
    localparam int unsigned CODE_W       = 8;
    localparam int unsigned SEARCH_STEPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_ROUND,
        ST_DONE
    } gamma_inv_state_t;

    // Curve level for one code: round(4095 * (c/255)^4), exact integer math.
    function automatic logic [LIN_W-1:0] gamma_level(input int c);
        logic [63:0] p;
        logic [63:0] num;
        p   = 64'(c) * 64'(c);
        p   = p * p;
        num = 64'd4095 * p + 64'd2114125312;
        return LIN_W'(num / 64'd4228250625);
    endfunction

endpackage

// File: rtl/gamma.sv
// 8-bit code to 12-bit linear LED level lookup table (combinational).
module gamma
    import gamma_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LIN_W-1:0]  level
);

    localparam int unsigned DEPTH = 1 << CODE_W;

    logic [LIN_W-1:0] lut [DEPTH];

    // Table entries are elaboration-time constants.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lut
        assign lut[i] = gamma_level(i);
    end

    assign level = lut[code];

endmodule

// File: rtl/gamma_inverse.sv
// Linear 12-bit intensity to 8-bit gamma code via MSB-first binary search over one gamma LUT.
// Optional nearest-code rounding step: define GAMMA_INVERSE_ROUND_EN.
module gamma_inverse
    import gamma_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIN_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data
);

    localparam int unsigned IDX_W = $clog2(SEARCH_STEPS);

    gamma_inv_state_t  state;
    logic [LIN_W-1:0]  target;
    logic [CODE_W-1:0] code;
    logic [IDX_W-1:0]  idx;

    logic [CODE_W-1:0] trial;
    logic [CODE_W-1:0] lut_code;
    logic [CODE_W-1:0] code_next;
    logic [LIN_W-1:0]  lut_level;
    logic              hit;

`ifdef GAMMA_INVERSE_ROUND_EN
    logic [LIN_W-1:0]  g_lo;
    logic              round_up;
`endif

    // Trial code and shared LUT address mux.
    always_comb begin
        trial     = code | (CODE_W'(1) << idx);
        lut_code  = trial;
`ifdef GAMMA_INVERSE_ROUND_EN
        if (state == ST_ROUND) begin
            lut_code = code + CODE_W'(1);
        end
`endif
        hit       = (lut_level <= target);
        code_next = hit ? trial : code;
    end

`ifdef GAMMA_INVERSE_ROUND_EN
    // Strictly closer upper neighbour wins; ties keep the floor code.
    always_comb begin
        round_up = (code != '1) && ((lut_level - target) < (target - g_lo));
    end
`endif

    gamma u_gamma (
        .code  (lut_code),
        .level (lut_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            target    <= '0;
            code      <= '0;
            idx       <= '0;
`ifdef GAMMA_INVERSE_ROUND_EN
            g_lo      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        target   <= in_data;
                        code     <= '0;
                        idx      <= IDX_W'(SEARCH_STEPS - 1);
                        in_ready <= 1'b0;
                        state    <= ST_SEARCH;
`ifdef GAMMA_INVERSE_ROUND_EN
                        g_lo     <= '0;
`endif
                    end
                end
                ST_SEARCH: begin
                    code <= code_next;
`ifdef GAMMA_INVERSE_ROUND_EN
                    if (hit) begin
                        g_lo <= lut_level;
                    end
`endif
                    if (idx == '0) begin
`ifdef GAMMA_INVERSE_ROUND_EN
                        state     <= ST_ROUND;
`else
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_data  <= code_next;
`endif
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
`ifdef GAMMA_INVERSE_ROUND_EN
                ST_ROUND: begin
                    code      <= round_up ? code + CODE_W'(1) : code;
                    out_data  <= round_up ? code + CODE_W'(1) : code;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gamma_inverse.md
# gamma_inverse

Sequential inverse of the 8→12-bit `gamma` LUT: converts a 12-bit linear LED intensity back to the 8-bit gamma-encoded code. Sits on the readback/diagnostic path between frame-buffer linear data and the 8-bit video/host side, so captured panel contents can be re-encoded. It performs an MSB-first binary search over a single shared `gamma` LUT instance, one bit per cycle, behind valid/ready handshakes on both sides.

## Interface
- No parameters; widths are fixed: linear 12 bits, code 8 bits.
- `clk`  in  1  system clock; one clock domain, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  linear sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  12  linear intensity, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  8  gamma code.

## Operation
- Result, floor mode: largest code c in 0x00..0xFF with gamma(c) <= target. gamma(0x00)=0, so a result always exists.
- States: IDLE, SEARCH, ROUND (macro only), DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register target=`in_data`; clear code and bit index to 7; clear g_lo to 0; go to SEARCH.
  - `in_data` is ignored after capture.
- SEARCH, one step per cycle, bit index 7 down to 0:
  - trial = code | (1<<idx).
  - If gamma(trial) <= target: code=trial and g_lo=gamma(trial).
  - After idx 0, go to ROUND if compiled in, else DONE.
- DONE:
  - `out_valid`=1; `out_data`=code, stable until handshake.
  - On `out_valid && out_ready`, go to IDLE.
- Comparisons and differences are 12-bit unsigned. Floor guarantees g_lo <= target < gamma(code+1) when code < 0xFF, so no underflow.
- Monotonic non-decreasing table: flat regions resolve to the highest code in the run. Example: target 0x000 → 0x1A.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after.
  - `out_valid`=0, `out_data`=0x00.
- Accept edge = cycle 0. Eight SEARCH edges follow.
- `out_valid` rises in cycle 9 (floor) or cycle 10 (rounding).
- `in_ready`=0 from cycle 1 until the cycle after the output handshake. No overlap between samples.
- Peak throughput: one sample per 10 cycles (11 with rounding), with `out_ready` held high.
- `out_ready` low in DONE: hold indefinitely, no loss.
- `out_ready` high before DONE: ignored.
- `rst` mid-search or in DONE: the in-flight sample is discarded. Outputs return to reset values on the next edge.

## Configuration
- `GAMMA_INVERSE_ROUND_EN` defined: adds the ROUND state, one cycle.
  - If code < 0xFF, evaluate g_hi=gamma(code+1).
  - If (g_hi − target) < (target − g_lo), code=code+1.
  - Ties keep the lower code. At code 0xFF, no change.
- Undefined: no ROUND state; floor result, latency 9.

## Structure
- Shared package `gamma_pkg`:
  - constants LIN_W=12, CODE_W=8, SEARCH_STEPS=8;
  - state enum type `gamma_inv_state_t`.
- Exactly one instance of the existing `gamma` LUT module. Its input is muxed: trial during SEARCH, code+1 during ROUND.
- No other sub-modules.

## Test plan
- 0x104 in, `out_ready`=1 → 0x80; `out_valid` first high in cycle 9 (10 with ROUND); `in_ready` low cycles 1..9.
- 0x000 → 0x1A; 0xFFF → 0xFF; 0xFFE → 0xFE. ROUND: 0xFFE → 0xFF.
- ROUND build, ties and nearest:
  - 0x108 → 0x80 (tie, 4 vs 4);
  - 0x10A → 0x81;
  - 0x105 → 0x80.
  - Floor build: all three → 0x80.
- Back-pressure: `out_ready`=0 for 20 cycles after `out_valid` → `out_data` stable, `in_valid` held high is not accepted; release → handshake, `in_ready` high next cycle.
- `rst` pulsed at cycle 4 of a search → next cycle IDLE, `out_valid`=0, `out_data`=0x00; next sample 0x104 → 0x80 normally.
- Exhaustive sweep: for all c, input gamma(c) → highest code sharing that gamma value; `in_data` toggled during search does not alter the result.
